// File: rtl/div_iter_if.sv
// Handshake bundle between the execute stage (master) and the iterative divider (slave).
// result_o packs {remainder, quotient}.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic                 start_i;
  logic                 signed_i;
  logic [WIDTH-1:0]     div_data1_i;
  logic [WIDTH-1:0]     div_data2_i;
  logic                 cancel_i;
  logic                 busy_o;
  logic                 done_o;
  logic [2*WIDTH-1:0]   result_o;

  modport master (
    output start_i, signed_i, div_data1_i, div_data2_i, cancel_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, signed_i, div_data1_i, div_data2_i, cancel_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per cycle, signed/unsigned,
// with flush cancel and defined divide-by-zero / overflow results.
//
// state | meaning
// IDLE  | waiting for start_i; operands sampled here
// CALC  | one shift/trial-subtract step per cycle, counter WIDTH-1 down to 0
// DONE  | done_o pulse, result_o valid; always returns to IDLE
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [WIDTH:0]       rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     dsr_q;
  logic                 neg_q;
  logic                 neg_r;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;

  logic [WIDTH+1:0]     shifted;
  logic [WIDTH+1:0]     trial;
  logic [WIDTH:0]       rem_n;
  logic [WIDTH-1:0]     quo_n;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic                 sgn_a;
  logic                 sgn_b;

  assign sgn_a = bus.signed_i & bus.div_data1_i[WIDTH-1];
  assign sgn_b = bus.signed_i & bus.div_data2_i[WIDTH-1];
  assign abs_a = sgn_a ? -bus.div_data1_i : bus.div_data1_i;
  assign abs_b = sgn_b ? -bus.div_data2_i : bus.div_data2_i;

  // Partial remainder stays below the divisor, so the shifted value never
  // reaches bit WIDTH+1 and that bit of the trial acts as a clean borrow.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {2'b00, dsr_q};
    if (trial[WIDTH+1]) begin
      rem_n = shifted[WIDTH:0];
      quo_n = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_n = trial[WIDTH:0];
      quo_n = {quo_q[WIDTH-2:0], 1'b1};
    end
    quo_fix = neg_q ? -quo_n : quo_n;
    rem_fix = neg_r ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (bus.cancel_i) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start_i) begin
            busy  <= 1'b1;
            neg_q <= sgn_a ^ sgn_b;
            neg_r <= sgn_a;
            if (bus.div_data2_i == '0) begin
              result <= {bus.div_data1_i, {WIDTH{1'b1}}};
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              quo_q <= abs_a;
              dsr_q <= abs_b;
              rem_q <= '0;
              cnt   <= CW'(WIDTH - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt   <= cnt - CW'(1);
          if (cnt == '0) begin
            result <= {rem_fix, quo_fix};
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o   = busy;
  assign bus.done_o   = done;
  assign bus.result_o = result;
endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter at WIDTH=32 and WIDTH=8: vector table, reference model
// for random operands, scoreboard queue, and cancel/reset/handshake sequences.
module tb_div_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(32)) b32();
  div_iter_if #(.WIDTH(8))  b8();

  div_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  div_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

  typedef struct {
    bit          w8;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] last32 = '0;
  vec_t        tv[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic dn(input bit w8);
    return w8 ? b8.done_o : b32.done_o;
  endfunction

  function automatic logic bs(input bit w8);
    return w8 ? b8.busy_o : b32.busy_o;
  endfunction

  function automatic logic [63:0] res(input bit w8);
    return w8 ? {48'b0, b8.result_o} : b32.result_o;
  endfunction

  task automatic set_in(input bit w8, input bit st, input bit sg,
                        input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      b8.start_i = st; b8.signed_i = sg; b8.div_data1_i = a[7:0]; b8.div_data2_i = b[7:0];
    end else begin
      b32.start_i = st; b32.signed_i = sg; b32.div_data1_i = a; b32.div_data2_i = b;
    end
  endtask

  task automatic clr_start(input bit w8);
    if (w8) b8.start_i = 1'b0;
    else    b32.start_i = 1'b0;
  endtask

  function automatic void model(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint la, lb;
    if (b == 32'd0) begin
      q = '1; r = a;
    end else if (!sg) begin
      q = a / b; r = a % b;
    end else begin
      la = longint'(signed'(a));
      lb = longint'(signed'(b));
      q = 32'(la / lb);
      r = 32'(la % lb);
    end
  endfunction

  // Counts edges from the cycle the request is presented until done_o.
  task automatic complete(input bit w8, input bit hold, input string nm);
    exp_t e;
    int   k = 0;
    bit   busy_ok = 1'b1;
    do begin
      @(posedge clk); #1;
      k++;
      if (k == 1 && !hold) clr_start(w8);
      busy_ok &= bs(w8);
    end while (!dn(w8) && k < 100);
    if (!dn(w8)) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: no done_o within %0d cycles", nm, k);
      if (sb.size() > 0) void'(sb.pop_front());
      clr_start(w8);
      return;
    end
    e = sb.pop_front();
    chk({nm, " latency"}, 64'(k), 64'(e.lat));
    chk({nm, " result"}, res(w8), e.res);
    chk({nm, " busy"}, 64'(busy_ok), 64'd1);
    if (!w8) last32 = e.res;
    if (!hold) begin
      @(posedge clk); #1;
      chk({nm, " pulse end"}, {62'b0, dn(w8), bs(w8)}, 64'd0);
    end
  endtask

  task automatic issue(input vec_t v, input string nm, input bit hold = 1'b0);
    exp_t e;
    bit   dz;
    dz    = v.w8 ? (v.b[7:0] == 8'd0) : (v.b == 32'd0);
    e.lat = dz ? 1 : (v.w8 ? 9 : 33);
    e.res = v.w8 ? {48'b0, v.r[7:0], v.q[7:0]} : {v.r, v.q};
    sb.push_back(e);
    set_in(v.w8, 1'b1, v.sgn, v.a, v.b);
    complete(v.w8, hold, nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   saw;
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_in(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    b32.cancel_i = 1'b0;
    b8.cancel_i  = 1'b0;

    tv[0]  = '{1'b0, 1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    tv[1]  = '{1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    tv[2]  = '{1'b0, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    tv[3]  = '{1'b0, 1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    tv[4]  = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    tv[5]  = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    tv[6]  = '{1'b0, 1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9};
    tv[7]  = '{1'b0, 1'b0, 32'd7,          32'd9,          32'd0,          32'd7};
    tv[8]  = '{1'b1, 1'b0, 32'h64,         32'h07,         32'h0E,         32'h02};
    tv[9]  = '{1'b1, 1'b1, 32'hF9,         32'h02,         32'hFD,         32'hFF};
    tv[10] = '{1'b1, 1'b1, 32'h80,         32'hFF,         32'h80,         32'h00};
    tv[11] = '{1'b1, 1'b0, 32'h05,         32'h00,         32'hFF,         32'h05};
    tv[12] = '{1'b1, 1'b1, 32'h07,         32'hFE,         32'hFD,         32'h01};
    tv[13] = '{1'b1, 1'b0, 32'hFF,         32'h01,         32'hFF,         32'h00};

    #1;
    chk("reset w32", {b32.result_o[61:0], b32.busy_o, b32.done_o}, 64'd0);
    chk("reset w32 res hi", {62'b0, b32.result_o[63:62]}, 64'd0);
    chk("reset w8", {46'b0, b8.result_o, b8.busy_o, b8.done_o}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    foreach (tv[i]) issue(tv[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      v.w8  = 1'b0;
      v.sgn = 1'($urandom_range(0, 1));
      v.a   = $urandom;
      v.b   = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      model(v.sgn, v.a, v.b, v.q, v.r);
      issue(v, $sformatf("rand%0d", i));
    end

    // Cancel mid-calculation: no completion, result keeps the previous value.
    set_in(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) clr_start(1'b0);
    end
    b32.cancel_i = 1'b1;
    @(posedge clk); #1;
    b32.cancel_i = 1'b0;
    chk("cancel busy", 64'(bs(1'b0)), 64'd0);
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      saw |= dn(1'b0);
    end
    chk("cancel no done", 64'(saw), 64'd0);
    chk("cancel result", res(1'b0), last32);
    v = '{1'b0, 1'b0, 32'd20, 32'd3, 32'd6, 32'd2};
    issue(v, "after cancel");

    // start_i held across DONE: a second operation starts from IDLE.
    v = '{1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2};
    issue(v, "hold first", 1'b1);
    set_in(1'b0, 1'b1, 1'b0, 32'd9, 32'd4);
    sb.push_back('{{32'd1, 32'd2}, 33});
    @(posedge clk); #1;
    chk("b2b idle gap", {62'b0, dn(1'b0), bs(1'b0)}, 64'd0);
    complete(1'b0, 1'b0, "b2b second");

    // start_i with cancel_i in IDLE: nothing starts.
    set_in(1'b0, 1'b1, 1'b0, 32'd50, 32'd5);
    b32.cancel_i = 1'b1;
    @(posedge clk); #1;
    chk("start+cancel busy", 64'(bs(1'b0)), 64'd0);
    clr_start(1'b0);
    b32.cancel_i = 1'b0;
    @(posedge clk); #1;
    chk("start+cancel idle", {62'b0, dn(1'b0), bs(1'b0)}, 64'd0);
    chk("start+cancel result", res(1'b0), last32);

    // Asynchronous reset in the middle of CALC.
    set_in(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (k == 1) clr_start(1'b0);
    end
    rst = 1'b1;
    #1;
    chk("async reset busy/done", {62'b0, dn(1'b0), bs(1'b0)}, 64'd0);
    chk("async reset result", res(1'b0), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last32 = '0;
    v = '{1'b0, 1'b0, 32'd9, 32'd4, 32'd2, 32'd1};
    issue(v, "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative restoring divider serving the execute stage's DIV.W/DIV.WU/MOD.W/MOD.WU operations. It replaces the fixed 32-bit divider behind the execute stage's `div_start`/`div_done` handshake. The block is generalised to any `WIDTH` and adds a pipeline-flush cancel, a `busy_o` indication and fully defined divide-by-zero and overflow results. The execute stage holds `start_i` and stalls until `done_o`, then takes the quotient from `result_o[WIDTH-1:0]` and the remainder from `result_o[2*WIDTH-1:WIDTH]`.

## Interface
- `WIDTH`, default 32: operand width, ≥ 4, power of two.

Ports (clock and reset first):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  request; sampled only in IDLE.
- `signed_i`  in  1  1 = two's-complement division, 0 = unsigned; sampled with `start_i`.
- `div_data1_i`  in  WIDTH  dividend; sampled with `start_i`.
- `div_data2_i`  in  WIDTH  divisor; sampled with `start_i`.
- `cancel_i`  in  1  flush; aborts any operation.
- `busy_o`  out  1  high in CALC and DONE.
- `done_o`  out  1  one-cycle completion pulse.
- `result_o`  out  2*WIDTH  {remainder, quotient}; holds its value until the next completion.

## Operation
- State machine: IDLE, CALC, DONE. All outputs are registered.
- IDLE:
  - `start_i`=1 and `cancel_i`=0 latches the operands, signedness and the operand sign bits.
  - Divisor == 0: go to DONE. The loaded result is quotient = all ones, remainder = dividend unchanged, for signed and unsigned.
  - Divisor ≠ 0: load |dividend| and |divisor| (magnitudes only when signed, raw values otherwise). Clear the partial remainder (WIDTH+1 bits). Set the counter to WIDTH−1. Go to CALC.
- CALC, each cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
  - Decrement the counter.
  - At counter 0, perform the final step, apply sign fix-up and go to DONE.
- Sign fix-up (signed only):
  - Negate the quotient when the operand signs differ.
  - Negate the remainder when the dividend is negative.
  - Arithmetic is modulo 2^WIDTH, so most-negative / −1 gives quotient = most-negative, remainder = 0 with no special case.
- DONE: `done_o`=1 for exactly this cycle, `result_o` is valid, then go to IDLE unconditionally.
- `result_o` updates only on entry to DONE. It is stable otherwise, including after a cancel.
- `cancel_i`=1 in any state: go to IDLE at the next edge.
  - `done_o` is not asserted in the cycle following the cancel edge.
  - `result_o` is unchanged.
- Simultaneous `cancel_i` and `start_i` in IDLE: cancel wins and nothing starts.
- Operand inputs may change freely after the sampling edge.

## Timing
- Reset (asynchronous, immediate): state IDLE, `busy_o`=0, `done_o`=0, `result_o`=0, counter 0.
- Let edge E0 be the edge that samples `start_i` in IDLE.
  - Divisor ≠ 0: CALC occupies edges E1..E(WIDTH). `done_o` is high in the cycle after edge E(WIDTH), i.e. WIDTH+1 cycles after the request is first presented. For WIDTH=32 that is 33 cycles.
  - Divisor = 0: `done_o` is high in the cycle after E0.
- `busy_o` rises in the cycle after E0 and falls in the cycle after DONE.
- Back-to-back operation: if `start_i` is still high in the cycle after DONE (state IDLE), a new operation starts at that edge. The execute stage drops `start_i` in its done cycle, so there is no duplicate issue.
- A DONE occurring in the same cycle as `cancel_i`=1 still shows `done_o`=1 in that cycle. The cancel only forces IDLE next, which DONE already does.

## Test plan
- Unsigned, WIDTH=32: 100 / 7 → quotient 14, remainder 2. `done_o` high exactly 33 cycles after `start_i` is first presented, for one cycle; `busy_o` high throughout.
- Signed: 0xFFFFFFF9 / 2 (−7/2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / 0xFFFFFFFE → quotient 0xFFFFFFFD, remainder 1.
- Boundaries:
  - 5 / 0 unsigned → {5, 0xFFFFFFFF}, `done_o` one cycle after the request.
  - 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0.
  - 0xFFFFFFFF / 1 unsigned → quotient 0xFFFFFFFF, remainder 0.
- Cancel: start 1000 / 3, assert `cancel_i` for 1 cycle at cycle 10. Required: no `done_o`, `result_o` unchanged. Then start 20 / 3 → quotient 6, remainder 2 after the full latency.
- Handshake: hold `start_i` high across DONE → a second operation starts from IDLE with freshly sampled operands. Separately, `start_i`+`cancel_i` together in IDLE → `busy_o` stays 0.
- Reset mid-CALC at cycle 15: all outputs 0 immediately (asynchronous). After release, 9 / 4 → quotient 2, remainder 1 with normal latency.
- Parametric: repeat the unsigned and signed cases at WIDTH=8 (e.g. 0x80 / 0xFF signed → quotient 0x80, remainder 0). `done_o` 9 cycles after the request.
